// File: rtl/lion_gate_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : lion_gate_conditioner                                     |
// | Brief  : Synchronises and debounces the two lion-cage light gates, |
// |          then decodes gate-break order into enter/exit events and  |
// |          flags illegal or stalled passages.                        |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module lion_gate_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic gate_one_raw,
  input  logic gate_two_raw,
  output logic gate_one,
  output logic gate_two,
  output logic enter_pulse,
  output logic exit_pulse,
  output logic seq_error,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value on the last differing cycle before the stable value flips.
  localparam logic [CNT_W-1:0] c_db_last  = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Timer value whose increment would land on TIMEOUT_CYCLES-1.
  localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_E1   = 3'd1,
    S_E2   = 3'd2,
    S_E3   = 3'd3,
    S_X1   = 3'd4,
    S_X2   = 3'd5,
    S_X3   = 3'd6,
    S_WAIT = 3'd7
  } state_t;

  // Bit 0 carries the outer gate, bit 1 the inner gate.
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] stable_w;
  logic [1:0] pair_w;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             enter_q, enter_d;
  logic             exit_q, exit_d;
  logic             error_q, error_d;
  logic             illegal_w;

  // Two-flop synchroniser next values; the only place raw inputs are read.
  always_comb begin
    sync1_d = {gate_two_raw, gate_one_raw};
    sync2_d = sync1_q;
  end

  // Synchroniser flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_debounce
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    // Count consecutive disagreeing cycles; adopt the new level on the last one.
    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q[i] != stable_q) begin
        if (cnt_q == c_db_last) begin
          stable_d = sync2_q[i];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // Debounce counter and stable level flops.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign stable_w[i] = stable_q;
  end

  assign gate_one = stable_w[0];
  assign gate_two = stable_w[1];
  // Outer gate as the high bit so 2'b10 reads "outer broken only".
  assign pair_w   = {gate_one, gate_two};

  // Direction FSM next state, passage timer and event pulses.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    enter_d   = 1'b0;
    exit_d    = 1'b0;
    error_d   = 1'b0;
    illegal_w = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        case (pair_w)
          2'b10:   state_d = S_E1;
          2'b01:   state_d = S_X1;
          2'b11:   illegal_w = 1'b1;
          default: state_d = S_IDLE;
        endcase
      end
      S_WAIT: begin
        timer_d = '0;
        if (pair_w == 2'b00) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        timer_d = timer_q + TMR_W'(1);
        // Completion outranks timeout, which outranks every other move.
        if (state_q == S_E3 && pair_w == 2'b00) begin
          enter_d = 1'b1;
          state_d = S_IDLE;
        end else if (state_q == S_X3 && pair_w == 2'b00) begin
          exit_d  = 1'b1;
          state_d = S_IDLE;
        end else if (timer_q == c_tmr_last) begin
          illegal_w = 1'b1;
        end else begin
          case (state_q)
            S_E1: case (pair_w)
              2'b00:   state_d = S_IDLE;
              2'b11:   state_d = S_E2;
              2'b01:   illegal_w = 1'b1;
              default: state_d = state_q;
            endcase
            S_E2: case (pair_w)
              2'b01:   state_d = S_E3;
              2'b10:   state_d = S_E1;
              2'b00:   illegal_w = 1'b1;
              default: state_d = state_q;
            endcase
            S_E3: case (pair_w)
              2'b11:   state_d = S_E2;
              2'b10:   illegal_w = 1'b1;
              default: state_d = state_q;
            endcase
            S_X1: case (pair_w)
              2'b00:   state_d = S_IDLE;
              2'b11:   state_d = S_X2;
              2'b10:   illegal_w = 1'b1;
              default: state_d = state_q;
            endcase
            S_X2: case (pair_w)
              2'b10:   state_d = S_X3;
              2'b01:   state_d = S_X1;
              2'b00:   illegal_w = 1'b1;
              default: state_d = state_q;
            endcase
            S_X3: case (pair_w)
              2'b11:   state_d = S_X2;
              2'b01:   illegal_w = 1'b1;
              default: state_d = state_q;
            endcase
            default: state_d = state_q;
          endcase
        end
      end
    endcase
    if (illegal_w) begin
      error_d = 1'b1;
      state_d = S_WAIT;
    end
  end

  // FSM state, timer and registered event pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
      error_q <= error_d;
    end
  end

  assign enter_pulse = enter_q;
  assign exit_pulse  = exit_q;
  assign seq_error   = error_q;
  assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lion_gate_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_lion_gate_conditioner                                  |
// | Brief  : Directed self-checking bench for lion_gate_conditioner    |
// |          with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64.                |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_lion_gate_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic gate_one_raw = 1'b0;
  logic gate_two_raw = 1'b0;
  logic gate_one, gate_two, enter_pulse, exit_pulse, seq_error, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int enter_cnt = 0;
  int exit_cnt = 0;
  int err_cnt = 0;
  int g1_hi = 0;
  int busy_hi = 0;
  int excl_bad = 0;
  int e0, x0, r0;

  lion_gate_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .gate_one_raw(gate_one_raw),
    .gate_two_raw(gate_two_raw),
    .gate_one    (gate_one),
    .gate_two    (gate_two),
    .enter_pulse (enter_pulse),
    .exit_pulse  (exit_pulse),
    .seq_error   (seq_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Advance n edges, sampling 1 time unit after each edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (enter_pulse) enter_cnt++;
      if (exit_pulse)  exit_cnt++;
      if (seq_error)   err_cnt++;
      if (gate_one)    g1_hi++;
      if (busy)        busy_hi++;
      if (int'(enter_pulse) + int'(exit_pulse) + int'(seq_error) > 1) excl_bad++;
    end
  endtask

  task automatic raw(input logic one, input logic two);
    gate_one_raw = one;
    gate_two_raw = two;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(2);
    chk_bit("rst_gate_one", gate_one, 1'b0);
    chk_bit("rst_gate_two", gate_two, 1'b0);
    chk_bit("rst_enter", enter_pulse, 1'b0);
    chk_bit("rst_exit", exit_pulse, 1'b0);
    chk_bit("rst_error", seq_error, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick(3);

    // Clean entry: 10, 11, 01, 00
    raw(1'b1, 1'b0);
    tick(5);
    chk_bit("entry_g1_before", gate_one, 1'b0);
    tick(1);
    chk_bit("entry_g1_edge6", gate_one, 1'b1);
    chk_bit("entry_busy_pre_e1", busy, 1'b0);
    tick(1);
    chk_bit("entry_busy_e1", busy, 1'b1);
    tick(3);
    raw(1'b1, 1'b1);
    tick(5);
    chk_bit("entry_g2_before", gate_two, 1'b0);
    tick(1);
    chk_bit("entry_g2_edge6", gate_two, 1'b1);
    tick(4);
    raw(1'b0, 1'b1);
    tick(6);
    chk_bit("entry_g1_fall", gate_one, 1'b0);
    tick(4);
    raw(1'b0, 1'b0);
    tick(6);
    chk_int("entry_no_early_pulse", enter_cnt, 0);
    chk_bit("entry_busy_e3", busy, 1'b1);
    tick(1);
    chk_bit("entry_pulse_edge7", enter_pulse, 1'b1);
    chk_bit("entry_busy_drop", busy, 1'b0);
    tick(3);
    chk_bit("entry_pulse_width", enter_pulse, 1'b0);
    chk_int("entry_enter_cnt", enter_cnt, 1);
    chk_int("entry_exit_cnt", exit_cnt, 0);
    chk_int("entry_err_cnt", err_cnt, 0);

    // Clean exit: 01, 11, 10, 00 then back-out 10, 00
    raw(1'b0, 1'b1); tick(10);
    raw(1'b1, 1'b1); tick(10);
    raw(1'b1, 1'b0); tick(10);
    raw(1'b0, 1'b0);
    tick(6);
    chk_int("exit_no_early_pulse", exit_cnt, 0);
    tick(1);
    chk_bit("exit_pulse_edge7", exit_pulse, 1'b1);
    tick(3);
    chk_int("exit_exit_cnt", exit_cnt, 1);
    raw(1'b1, 1'b0); tick(10);
    chk_bit("backout_busy_e1", busy, 1'b1);
    raw(1'b0, 1'b0); tick(10);
    chk_bit("backout_busy_idle", busy, 1'b0);
    chk_int("backout_enter_cnt", enter_cnt, 1);
    chk_int("backout_exit_cnt", exit_cnt, 1);
    chk_int("backout_err_cnt", err_cnt, 0);

    // Bounce rejection: five 3-cycle glitches on the outer gate
    g1_hi = 0;
    busy_hi = 0;
    for (int g = 0; g < 5; g++) begin
      raw(1'b1, 1'b0); tick(3);
      raw(1'b0, 1'b0); tick(3);
    end
    tick(10);
    chk_int("bounce_g1_never_high", g1_hi, 0);
    chk_int("bounce_busy_never_high", busy_hi, 0);
    chk_int("bounce_enter_cnt", enter_cnt, 1);
    chk_int("bounce_exit_cnt", exit_cnt, 1);
    chk_int("bounce_err_cnt", err_cnt, 0);
    // A 4-cycle hold is long enough to pass
    raw(1'b1, 1'b0); tick(4);
    raw(1'b0, 1'b0); tick(12);
    chk_bit("hold4_g1_seen", g1_hi > 0, 1'b1);
    tick(10);
    chk_bit("hold4_busy_idle", busy, 1'b0);
    chk_int("hold4_err_cnt", err_cnt, 0);

    // Illegal: both gates break together
    raw(1'b1, 1'b1);
    tick(12);
    chk_int("illegal_err_cnt", err_cnt, 1);
    chk_bit("illegal_busy_11", busy, 1'b1);
    raw(1'b0, 1'b1); tick(10);
    chk_bit("illegal_busy_01", busy, 1'b1);
    raw(1'b0, 1'b0); tick(10);
    chk_bit("illegal_busy_clear", busy, 1'b0);
    chk_int("illegal_err_once", err_cnt, 1);
    chk_int("illegal_enter_cnt", enter_cnt, 1);
    chk_int("illegal_exit_cnt", exit_cnt, 1);

    // Timeout: E1 entered 7 edges after applying 10, error 63 edges later
    raw(1'b1, 1'b0);
    tick(69);
    chk_int("timeout_not_yet", err_cnt, 1);
    chk_bit("timeout_busy_before", busy, 1'b1);
    tick(1);
    chk_bit("timeout_error_edge", seq_error, 1'b1);
    tick(30);
    chk_int("timeout_err_once", err_cnt, 2);
    raw(1'b1, 1'b1); tick(10);
    raw(1'b0, 1'b1); tick(10);
    chk_bit("timeout_busy_wait", busy, 1'b1);
    raw(1'b0, 1'b0); tick(10);
    chk_bit("timeout_busy_clear", busy, 1'b0);
    chk_int("timeout_no_enter", enter_cnt, 1);
    chk_int("timeout_err_final", err_cnt, 2);

    // Reset mid-passage while in E2
    e0 = enter_cnt;
    x0 = exit_cnt;
    r0 = err_cnt;
    raw(1'b1, 1'b0); tick(10);
    raw(1'b1, 1'b1); tick(10);
    chk_bit("midrst_busy_e2", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_bit("midrst_gate_one", gate_one, 1'b0);
    chk_bit("midrst_gate_two", gate_two, 1'b0);
    chk_bit("midrst_busy", busy, 1'b0);
    chk_bit("midrst_enter", enter_pulse, 1'b0);
    chk_bit("midrst_exit", exit_pulse, 1'b0);
    chk_bit("midrst_error", seq_error, 1'b0);
    raw(1'b1, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(5);
    chk_bit("postrst_g1_before", gate_one, 1'b0);
    tick(1);
    chk_bit("postrst_g1_edge6", gate_one, 1'b1);
    tick(4);
    raw(1'b1, 1'b1); tick(10);
    raw(1'b0, 1'b1); tick(10);
    raw(1'b0, 1'b0); tick(10);
    chk_int("postrst_enter_once", enter_cnt, e0 + 1);
    chk_int("postrst_exit_none", exit_cnt, x0);
    chk_int("postrst_err_none", err_cnt, r0);
    chk_bit("postrst_busy_idle", busy, 1'b0);

    chk_int("pulse_exclusion", excl_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lion_gate_conditioner.md
# lion_gate_conditioner

Upstream conditioning stage for the lion-cage counter. It takes the two raw light-gate inputs, synchronises and debounces each one, and drives clean gate levels that feed the counter's gate inputs. It also decodes the gate-break sequence into single-cycle enter and exit events. Invalid or stalled sequences are flagged, so downstream display or alarm logic never acts on bounce or partial passages.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised input must differ from its stable value before the stable value changes; must be >= 1.
- TIMEOUT_CYCLES, 1024: maximum cycles a passage sequence may stay open before it is aborted; must be >= 2.
- clk  in  1  single clock; all flops are on its rising edge.
- reset  in  1  asynchronous, active-high; clears every flop immediately.
- gate_one_raw  in  1  raw outer gate; 1 = beam broken.
- gate_two_raw  in  1  raw inner gate; 1 = beam broken.
- gate_one  out  1  debounced outer gate level; drives the counter's first gate input.
- gate_two  out  1  debounced inner gate level; drives the counter's second gate input.
- enter_pulse  out  1  one-cycle pulse per completed outer-to-inner passage.
- exit_pulse  out  1  one-cycle pulse per completed inner-to-outer passage.
- seq_error  out  1  one-cycle pulse on an illegal transition or timeout.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Reset values.** All outputs are 0, both synchronisers are 0, both debounce counters are 0, the FSM is in IDLE and the timer is 0.
- **Synchroniser.** Each raw input passes through two flops. Nothing else samples the raw inputs.
- **Debounce, per channel.**
  - The counter has width $clog2(DEBOUNCE_CYCLES+1).
  - When the synchronised value equals the stable value, the counter is cleared to 0.
  - Otherwise the counter increments. On the DEBOUNCE_CYCLES-th consecutive differing cycle, the stable value takes the synchronised value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches gate_one or gate_two.
  - gate_one and gate_two are the stable flops themselves.
- **Direction FSM.** It runs on the pair {gate_one, gate_two}, written below as two bits (gate_one first).
  - IDLE:
    - 10 -> E1.
    - 01 -> X1.
    - 11 -> ERR (both gates broke in the same cycle).
  - E1:
    - 00 -> IDLE, no event (the lion backed out).
    - 11 -> E2.
    - 01 -> ERR.
  - E2:
    - 01 -> E3.
    - 10 -> E1.
    - 00 -> ERR.
  - E3:
    - 00 -> IDLE with enter_pulse.
    - 11 -> E2.
    - 10 -> ERR.
  - X1, X2, X3 mirror E1, E2, E3 with the gates swapped. X3 on 00 -> IDLE with exit_pulse.
  - Any state with an unchanged pair stays where it is.
- **ERR handling.** ERR is not a state. It means: assert seq_error for one cycle and go to WAIT_CLEAR.
- **WAIT_CLEAR.** Stays until the pair reads 00, then goes to IDLE. No events are produced while in WAIT_CLEAR.
- **Timer.**
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - Cleared in IDLE and WAIT_CLEAR.
  - Increments every cycle in the E and X states.
  - When it reaches TIMEOUT_CYCLES-1 and no completing transition occurs in that cycle: seq_error, go to WAIT_CLEAR.
- **Priority in one cycle.** A completing transition (E3 or X3 on 00) beats a timeout. A timeout beats any other transition.
- **busy** is 1 in every state except IDLE.

## Timing
- **Raw to clean level.** A raw change that is held steady appears on gate_one or gate_two after edge 2+DEBOUNCE_CYCLES, counted from the first edge that samples it.
- **Clean level to event.** enter_pulse, exit_pulse and seq_error are registered together with the FSM state. They rise at the edge after the triggering level is visible and last exactly one cycle.
- **Overall latency.** Last raw gate clearing to the event pulse is 3+DEBOUNCE_CYCLES edges.
- **Mutual exclusion.** enter_pulse, exit_pulse and seq_error are never high in the same cycle.
- **Back-to-back passages.** Passages may follow each other with no idle gap beyond the single cycle spent in IDLE.
- **Reset mid-sequence.** It aborts the passage with no pulse. After release the FSM starts in IDLE. If the gates are still broken, the bench must see the normal debounce latency before any transition.

## Test plan
The bench uses DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=64.
- **Clean entry.**
  - Stimulus: raw sequence 10, 11, 01, 00, each held 10 cycles.
  - Required: exactly one enter_pulse, 7 edges after the final 00 is applied.
  - Required: gate_one and gate_two follow the raw values with a 6-edge delay; busy is high from E1 until the pulse.
- **Clean exit plus back-out.**
  - Stimulus: 01, 11, 10, 00 gives one exit_pulse. Then 10, 00.
  - Required: no further pulse, and busy drops back to 0.
- **Bounce rejection.**
  - Stimulus: 3-cycle high glitches on gate_one_raw, repeated 5 times.
  - Required: gate_one stays 0, no pulses, busy stays 0.
  - Follow-up: a 4-cycle hold must raise gate_one.
- **Illegal sequence.**
  - Stimulus: both raw gates rise in the same cycle (11 from IDLE).
  - Required: one seq_error pulse, busy stays 1 until both gates clear, no enter_pulse or exit_pulse.
- **Timeout.**
  - Stimulus: hold 10 for 100 cycles.
  - Required: seq_error exactly once, 63 cycles after E1 is entered. Then the sequence 11, 01, 00 produces no enter_pulse, and busy clears on 00.
- **Reset mid-passage.**
  - Stimulus: assert reset asynchronously while the FSM is in E2.
  - Required: all outputs go to 0 immediately, without waiting for a clock edge. A full entry afterwards yields exactly one enter_pulse.
